// File: rtl/output_arbiter.sv
// output_arbiter: round-robin arbiter sharing one output unit among N four-phase req/ack requesters.
// Each value is fully handshaken downstream before the originating requester is acknowledged.
module output_arbiter #(
  parameter int DW = 16,
  parameter int N  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*DW-1:0] data,
  output logic [N-1:0]    ack,
  output logic            out_req,
  output logic [DW-1:0]   out_data,
  input  logic            out_ack,
  output logic [2:0]      grant_id,
  output logic            busy,
  output logic [15:0]     count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RELEASE,
    S_RESPOND
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [2:0]    r_ptr, w_ptr_nxt;
  logic [2:0]    r_gid, w_gid_nxt;
  logic [N-1:0]  r_ack, w_ack_nxt;
  logic          r_out_req, w_out_req_nxt;
  logic [DW-1:0] r_out_data, w_out_data_nxt;
  logic          r_busy, w_busy_nxt;
  logic [15:0]   r_count, w_count_nxt;

  logic [7:0]    w_req8;
  logic [DW-1:0] w_slot [8];
  logic          w_found;
  logic [2:0]    w_sel;
  logic [2:0]    w_idx;
  logic [N-1:0]  w_gid_onehot;

  // Requests and data slices padded to 8 entries so a 3-bit index always fits.
  assign w_req8 = 8'(req);

  for (genvar g = 0; g < 8; g++) begin : g_slot
    if (g < N) begin : g_used
      assign w_slot[g] = data[g*DW +: DW];
    end else begin : g_pad
      assign w_slot[g] = '0;
    end
  end

  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_idx = 3'((32'(r_ptr) + k) % N);
      if (!w_found && w_req8[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  always_comb begin
    w_gid_onehot = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_gid_onehot[i] = (r_gid == 3'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_gid      <= '0;
      r_ack      <= '0;
      r_out_req  <= 1'b0;
      r_out_data <= '0;
      r_busy     <= 1'b0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_gid      <= w_gid_nxt;
      r_ack      <= w_ack_nxt;
      r_out_req  <= w_out_req_nxt;
      r_out_data <= w_out_data_nxt;
      r_busy     <= w_busy_nxt;
      r_count    <= w_count_nxt;
    end
  end

  // A high out_ack in IDLE is a downstream still draining an aborted transaction; never grant on it.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:    if (w_found && !out_ack) w_state_nxt = S_ISSUE;
      S_ISSUE:   if (out_ack)             w_state_nxt = S_RELEASE;
      S_RELEASE: if (!out_ack)            w_state_nxt = S_RESPOND;
      S_RESPOND: if (!w_req8[r_gid])      w_state_nxt = S_IDLE;
      default:                            w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_ptr_nxt      = r_ptr;
    w_gid_nxt      = r_gid;
    w_ack_nxt      = r_ack;
    w_out_req_nxt  = r_out_req;
    w_out_data_nxt = r_out_data;
    w_busy_nxt     = r_busy;
    w_count_nxt    = r_count;
    if (w_state_nxt != r_state) begin
      unique case (r_state)
        S_IDLE: begin
          w_gid_nxt      = w_sel;
          w_out_data_nxt = w_slot[w_sel];
          w_out_req_nxt  = 1'b1;
          w_busy_nxt     = 1'b1;
        end
        S_ISSUE: begin
          w_out_req_nxt = 1'b0;
        end
        S_RELEASE: begin
          w_ack_nxt   = w_gid_onehot;
          w_count_nxt = r_count + 16'd1;
        end
        S_RESPOND: begin
          w_ack_nxt  = '0;
          w_ptr_nxt  = (r_gid == 3'(N - 1)) ? '0 : r_gid + 3'd1;
          w_busy_nxt = 1'b0;
        end
        default: begin
          w_busy_nxt = 1'b0;
        end
      endcase
    end
  end

  assign ack      = r_ack;
  assign out_req  = r_out_req;
  assign out_data = r_out_data;
  assign grant_id = r_gid;
  assign busy     = r_busy;
  assign count    = r_count;

endmodule

// File: tb/tb_output_arbiter.sv
// tb_output_arbiter: directed scenarios plus randomized traffic, checked every cycle against a
// transaction-level model of the arbiter, with a behavioural output unit and requesters.
module tb_output_arbiter;
  localparam int DW = 16;
  localparam int N  = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] data = '0;
  logic            out_ack = 1'b0;
  logic [N-1:0]    ack;
  logic            out_req;
  logic [DW-1:0]   out_data;
  logic [2:0]      grant_id;
  logic            busy;
  logic [15:0]     count;

  output_arbiter #(.DW(DW), .N(N)) dut (
    .clk(clk), .rst(rst), .req(req), .data(data), .ack(ack),
    .out_req(out_req), .out_data(out_data), .out_ack(out_ack),
    .grant_id(grant_id), .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s @%0t: timed out waiting on DUT, got no event, expected one", name, $time);
  endtask

  // ---------------- environment: requesters and output unit ----------------
  int  pend [N];
  int  fix_val [N];
  bit  drop_on_issue [N];
  bit  rand_mode   = 1'b0;
  bit  ds_override = 1'b0;
  int  ds_state    = 0;
  int  ds_cnt      = 0;
  int  ds_lat      = 2;
  logic ds_q       = 1'b0;

  function automatic int pend_total();
    int s = 0;
    for (int i = 0; i < N; i++) s += pend[i];
    return s;
  endfunction

  initial begin
    for (int i = 0; i < N; i++) begin
      pend[i] = 0;
      fix_val[i] = -1;
      drop_on_issue[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      // Output unit acts on the out_req it registered one edge earlier (IDLE->WRITE->DONE).
      if (!ds_override) begin
        case (ds_state)
          0: if (ds_q) begin
               ds_state = 1;
               ds_cnt = 0;
               ds_lat = rand_mode ? int'($urandom_range(1, 4)) : 2;
             end
          1: begin
               ds_cnt++;
               if (ds_cnt >= ds_lat) begin
                 out_ack = 1'b1;
                 ds_state = 2;
                 $display("OUT> %0d", out_data);
               end
             end
          default: if (!ds_q) begin
               out_ack = 1'b0;
               ds_state = 0;
             end
        endcase
      end
      ds_q = out_req;
      if (rand_mode && $urandom_range(0, 19) == 0) pend[$urandom_range(0, N - 1)]++;
      for (int i = 0; i < N; i++) begin
        if (req[i] && ack[i]) begin
          req[i] = 1'b0;
        end else if (!req[i] && !ack[i] && pend[i] > 0) begin
          req[i] = 1'b1;
          data[i*DW +: DW] = (fix_val[i] >= 0) ? DW'(fix_val[i]) : DW'($urandom);
          pend[i]--;
        end else if (req[i] && out_req && grant_id == 3'(i)) begin
          if (drop_on_issue[i] || (rand_mode && $urandom_range(0, 29) == 0)) begin
            req[i] = 1'b0;
            drop_on_issue[i] = 1'b0;
          end else if (rand_mode && $urandom_range(0, 9) == 0) begin
            data[i*DW +: DW] = DW'($urandom);
          end
        end
      end
    end
  end

  // ---------------- reference model and per-cycle compare ----------------
  int            m_phase = 0;   // 0 idle, 1 waiting out_ack high, 2 waiting out_ack low, 3 waiting req low
  int            m_ptr   = 0;
  int            m_gid   = 0;
  logic          m_oreq  = 1'b0;
  logic          m_busy  = 1'b0;
  logic [DW-1:0] m_odata = '0;
  logic [N-1:0]  m_ack   = '0;
  logic [15:0]   m_cnt   = '0;
  bit            m_valid = 1'b0;
  bit            preload_req = 1'b0;
  logic          prev_oreq = 1'b0;
  int            grants[$];

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_phase = 0; m_ptr = 0; m_gid = 0; m_oreq = 1'b0; m_odata = '0;
        m_ack = '0; m_busy = 1'b0; m_cnt = '0; m_valid = 1'b1;
      end else begin
        if (preload_req) begin
          m_cnt = 16'hFFFF;
          preload_req = 1'b0;
        end
        case (m_phase)
          0: if (req != '0 && !out_ack) begin
               for (int k = 0; k < N; k++) begin
                 if (req[(m_ptr + k) % N]) begin
                   m_gid = (m_ptr + k) % N;
                   break;
                 end
               end
               m_odata = data[m_gid*DW +: DW];
               m_oreq = 1'b1;
               m_busy = 1'b1;
               m_phase = 1;
             end
          1: if (out_ack) begin
               m_oreq = 1'b0;
               m_phase = 2;
             end
          2: if (!out_ack) begin
               m_ack = '0;
               m_ack[m_gid] = 1'b1;
               m_cnt = m_cnt + 16'd1;
               m_phase = 3;
             end
          default: if (!req[m_gid]) begin
               m_ack = '0;
               m_ptr = (m_gid + 1) % N;
               m_busy = 1'b0;
               m_phase = 0;
             end
        endcase
      end
      #1;
      if (m_valid) begin
        n_chk++;
        if ({ack, out_req, out_data, grant_id, busy, count} !==
            {m_ack, m_oreq, m_odata, 3'(m_gid), m_busy, m_cnt}) begin
          n_fail++;
          $display("FAIL cycle_outputs @%0t: got ack=%b out_req=%b out_data=%h grant_id=%0d busy=%b count=%h, expected ack=%b out_req=%b out_data=%h grant_id=%0d busy=%b count=%h",
                   $time, ack, out_req, out_data, grant_id, busy, count,
                   m_ack, m_oreq, m_odata, m_gid, m_busy, m_cnt);
        end
        if (out_req && !prev_oreq) grants.push_back(int'(grant_id));
        prev_oreq = out_req;
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_grant(input string name);
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (out_req) return;
    end
    timeout(name);
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #1;
      if (!busy && req == '0 && !out_ack && ds_state == 0 && pend_total() == 0) return;
    end
    timeout(name);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  int k;
  bit got;
  int exp_order [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got hang, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("reset_state", {ack, out_req, out_data, grant_id, busy, count}, '0);

    // Single request with a known value.
    @(negedge clk);
    fix_val[0] = 1234;
    pend[0] = 1;
    k = 0; got = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      if (req[0]) k++;
      #1;
      if (out_req) begin got = 1'b1; break; end
    end
    if (!got) timeout("t1_grant");
    check("t1_req_edges_before_grant", k, 1);
    check("t1_out_data", out_data, 1234);
    check("t1_grant_id", grant_id, 0);
    k = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      k++;
      if (ack[0]) break;
    end
    check("t1_ack_latency", k, 6);
    wait_idle("t1_idle", 100);
    fix_val[0] = -1;
    check("t1_count", count, 1);

    // Round-robin fairness from a fresh pointer.
    do_reset();
    grants.delete();
    pend[0] = 2; pend[1] = 2; pend[2] = 1; pend[3] = 1;
    wait_idle("t2_idle", 400);
    check("t2_num_grants", grants.size(), 6);
    for (int i = 0; i < 6 && i < grants.size(); i++) check($sformatf("t2_grant_%0d", i), grants[i], exp_order[i]);
    check("t2_count", count, 6);

    // Stale out_ack must hold off a grant.
    @(negedge clk);
    ds_override = 1'b1;
    out_ack = 1'b1;
    pend[1] = 1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("t3_no_out_req", out_req, 0);
      check("t3_not_busy", busy, 0);
    end
    @(negedge clk);
    out_ack = 1'b0;
    ds_override = 1'b0;
    @(posedge clk); #1;
    check("t3_grant_after_ack_low", out_req, 1);
    check("t3_grant_id", grant_id, 1);
    wait_idle("t3_idle", 100);

    // Reset while the downstream transaction is in flight.
    pend[2] = 1;
    wait_grant("t4_grant");
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("t4_rst_state", {ack, out_req, busy, count, grant_id}, '0);
    @(negedge clk); rst = 1'b0;
    wait_grant("t4_regrant");
    check("t4_grant_id", grant_id, 2);
    wait_idle("t4_idle", 100);
    check("t4_count", count, 1);

    // Early drop by requester 3.
    @(negedge clk);
    drop_on_issue[3] = 1'b1;
    pend[3] = 1;
    wait_grant("t5_grant");
    check("t5_grant_id", grant_id, 3);
    k = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (ack[3]) k++;
      if (!busy) break;
    end
    check("t5_ack_pulse_cycles", k, 1);
    wait_idle("t5_idle", 100);
    check("t5_count", count, 2);
    @(negedge clk);
    pend[0] = 1; pend[3] = 1;
    wait_grant("t5_next_grant");
    check("t5_ptr_wrapped_to_0", grant_id, 0);
    wait_idle("t5_idle2", 200);

    // Counter wrap.
    @(negedge clk);
    force dut.r_count = 16'hFFFF;
    preload_req = 1'b1;
    @(negedge clk);
    release dut.r_count;
    check("t6_preloaded", count, 16'hFFFF);
    pend[2] = 1;
    wait_idle("t6_idle", 100);
    check("t6_count_wrapped", count, 0);

    // Randomized traffic with occasional resets.
    rand_mode = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 599) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    rand_mode = 1'b0;
    wait_idle("t7_drain", 3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
